// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single CPU-side mmu memory port among MASTERS
// requesters. A round-robin winner is picked in IDLE. Its request is issued to
// the mmu for exactly one cycle, and its address is held through the device
// read latency. The result is returned with a one-cycle ack.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   m_req/m_we/m_addr/m_wd/m_unit per-master request fields (packed per master)
//   m_ack                         one-hot completion pulse
//   m_rd, m_access_fault,
//   m_addr_misaligned             completion data and fault flags, valid with m_ack
//   grant                         one-hot current owner, 0 when idle
//   mem_re/mem_we/mem_addr/mem_wd,
//   mem_rd_unit/mem_wd_unit       drive the mmu port
//   mem_rd, access_fault,
//   addr_misaligned               mmu responses (faults combinational from mem_*)
module mem_bus_arbiter #(
    parameter int unsigned MASTERS    = 2,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [MASTERS-1:0]     m_req,
    input  logic [MASTERS-1:0]     m_we,
    input  logic [MASTERS*32-1:0]  m_addr,
    input  logic [MASTERS*32-1:0]  m_wd,
    input  logic [MASTERS*2-1:0]   m_unit,
    output logic [MASTERS-1:0]     m_ack,
    output logic [31:0]            m_rd,
    output logic                   m_access_fault,
    output logic                   m_addr_misaligned,
    output logic [MASTERS-1:0]     grant,
    output logic                   mem_re,
    output logic                   mem_we,
    output logic [31:0]            mem_addr,
    output logic [31:0]            mem_wd,
    output logic [1:0]             mem_rd_unit,
    output logic [1:0]             mem_wd_unit,
    input  logic [31:0]            mem_rd,
    input  logic                   access_fault,
    input  logic                   addr_misaligned
);

    localparam int unsigned IdxW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam logic [2:0] CntInit = (RD_LATENCY == 0) ? 3'd0 : 3'(RD_LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     last_q, last_d;
    logic [IdxW-1:0]     owner_q, owner_d;
    logic                we_q, we_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [MASTERS-1:0]  grant_q, grant_d;
    logic                mem_re_q, mem_re_d;
    logic                mem_we_q, mem_we_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wd_q, wd_d;
    logic [1:0]          unit_q, unit_d;
    logic [MASTERS-1:0]  ack_q, ack_d;
    logic [31:0]         rd_q, rd_d;
    logic                af_q, af_d;
    logic                am_q, am_d;

    // Round-robin pick: first requester scanning from last+1 with wrap-around.
    logic                pick_valid;
    logic [IdxW-1:0]     pick_idx;
    logic [IdxW-1:0]     cand;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 1; i <= MASTERS; i++) begin
            cand = IdxW'((32'(last_q) + i) % MASTERS);
            if (!pick_valid && m_req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        mem_re_d = 1'b0;
        mem_we_d = 1'b0;
        addr_d   = addr_q;
        wd_d     = wd_q;
        unit_d   = unit_q;
        ack_d    = '0;
        rd_d     = rd_q;
        af_d     = af_q;
        am_d     = am_q;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    owner_d           = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    we_d              = m_we[pick_idx];
                    addr_d            = m_addr[32*pick_idx +: 32];
                    wd_d              = m_wd[32*pick_idx +: 32];
                    unit_d            = m_unit[2*pick_idx +: 2];
                    mem_re_d          = !m_we[pick_idx];
                    mem_we_d          = m_we[pick_idx];
                    state_d           = StIssue;
                end
            end
            StIssue: begin
                // Faults are only meaningful while the access is being issued.
                af_d = access_fault;
                am_d = addr_misaligned;
                if (access_fault || addr_misaligned || we_q) begin
                    rd_d           = '0;
                    ack_d[owner_q] = 1'b1;
                    state_d        = StDone;
                end else if (RD_LATENCY == 0) begin
                    rd_d           = mem_rd;
                    ack_d[owner_q] = 1'b1;
                    state_d        = StDone;
                end else begin
                    cnt_d   = CntInit;
                    state_d = StWait;
                end
            end
            StWait: begin
                // Address and units stay put: the mmu routes rd by address.
                if (cnt_q == 3'd0) begin
                    rd_d           = mem_rd;
                    ack_d[owner_q] = 1'b1;
                    state_d        = StDone;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StDone: begin
                last_d  = owner_q;
                grant_d = '0;
                rd_d    = '0;
                af_d    = 1'b0;
                am_d    = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            last_q   <= IdxW'(MASTERS - 1);
            owner_q  <= '0;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            grant_q  <= '0;
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            addr_q   <= '0;
            wd_q     <= '0;
            unit_q   <= '0;
            ack_q    <= '0;
            rd_q     <= '0;
            af_q     <= 1'b0;
            am_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            mem_re_q <= mem_re_d;
            mem_we_q <= mem_we_d;
            addr_q   <= addr_d;
            wd_q     <= wd_d;
            unit_q   <= unit_d;
            ack_q    <= ack_d;
            rd_q     <= rd_d;
            af_q     <= af_d;
            am_q     <= am_d;
        end
    end

    assign m_ack             = ack_q;
    assign m_rd              = rd_q;
    assign m_access_fault    = af_q;
    assign m_addr_misaligned = am_q;
    assign grant             = grant_q;
    assign mem_re            = mem_re_q;
    assign mem_we            = mem_we_q;
    assign mem_addr          = addr_q;
    assign mem_wd            = wd_q;
    assign mem_rd_unit       = unit_q;
    assign mem_wd_unit       = unit_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: a small mmu/device model answers the memory
// port, and a transaction-level reference model (round-robin choice plus
// fixed latencies and a shadow memory) predicts every grant, issue and ack.
module tb_mem_bus_arbiter;

    localparam int MASTERS    = 2;
    localparam int RD_LATENCY = 1;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [MASTERS-1:0]    m_req = '0;
    logic [MASTERS-1:0]    m_we = '0;
    logic [MASTERS*32-1:0] m_addr = '0;
    logic [MASTERS*32-1:0] m_wd = '0;
    logic [MASTERS*2-1:0]  m_unit = '0;
    logic [MASTERS-1:0]    m_ack;
    logic [31:0]           m_rd;
    logic                  m_access_fault;
    logic                  m_addr_misaligned;
    logic [MASTERS-1:0]    grant;
    logic                  mem_re;
    logic                  mem_we;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_wd;
    logic [1:0]            mem_rd_unit;
    logic [1:0]            mem_wd_unit;
    logic [31:0]           mem_rd;
    logic                  access_fault;
    logic                  addr_misaligned;

    mem_bus_arbiter #(.MASTERS(MASTERS), .RD_LATENCY(RD_LATENCY)) dut (
        .clk              (clk),
        .reset            (reset),
        .m_req            (m_req),
        .m_we             (m_we),
        .m_addr           (m_addr),
        .m_wd             (m_wd),
        .m_unit           (m_unit),
        .m_ack            (m_ack),
        .m_rd             (m_rd),
        .m_access_fault   (m_access_fault),
        .m_addr_misaligned(m_addr_misaligned),
        .grant            (grant),
        .mem_re           (mem_re),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wd           (mem_wd),
        .mem_rd_unit      (mem_rd_unit),
        .mem_wd_unit      (mem_wd_unit),
        .mem_rd           (mem_rd),
        .access_fault     (access_fault),
        .addr_misaligned  (addr_misaligned)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- mmu / device environment ----------------
    // RAM at 0x4000_0xxx (16 words), read-only ROM at 0x8000_0xxx, rest faults.
    // Units: 0 byte, 1 half, 2 word.
    function automatic logic mmu_fault(input logic [31:0] a, input logic we);
        if (a[31:12] == 20'h40000) return 1'b0;
        if (a[31:12] == 20'h80000) return we;
        return 1'b1;
    endfunction

    function automatic logic mmu_misaligned(input logic [31:0] a, input logic [1:0] u);
        return (u == 2'd1 && a[0]) || (u == 2'd2 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return ~{a[31:2], 2'b00};
    endfunction

    logic [31:0] dev_mem [16];
    logic [31:0] dev_rd = '0;

    assign access_fault    = mmu_fault(mem_addr, mem_we);
    assign addr_misaligned = mmu_misaligned(mem_addr, mem_rd_unit);
    assign mem_rd          = dev_rd;

    always @(posedge clk) begin
        if (mem_we && !access_fault && !addr_misaligned && mem_addr[31:12] == 20'h40000)
            dev_mem[mem_addr[5:2]] <= mem_wd;
        if (mem_re)
            dev_rd <= (mem_addr[31:12] == 20'h40000) ? dev_mem[mem_addr[5:2]]
                                                     : rom_word(mem_addr);
    end

    // ---------------- reference model ----------------
    logic [31:0] shadow [16];
    bit          chk_en = 1'b0;
    int          cyc = 0;
    bit          busy = 1'b0;
    int          mdl_last = MASTERS - 1;
    int          owner, issue_at, ack_at, cand;
    bit          found;
    logic        t_we, t_flt, t_mis;
    logic [31:0] t_addr, t_wd, exp_rd;
    logic [1:0]  t_unit;
    logic [MASTERS-1:0] exp_grant, exp_ack;
    logic [MASTERS-1:0] ack_prev = '0;
    logic [31:0] ack_rd_prev = '0;
    logic        ack_af_prev = 1'b0;
    logic        ack_am_prev = 1'b0;

    initial begin
        for (int i = 0; i < 16; i++) begin
            dev_mem[i] = '0;
            shadow[i]  = '0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            exp_grant = '0;
            exp_ack   = '0;
            if (busy) exp_grant[owner] = 1'b1;
            if (busy && cyc == ack_at) exp_ack[owner] = 1'b1;
            check_val("grant", 32'(grant), 32'(exp_grant));
            check_val("mem_re", 32'(mem_re), 32'(busy && cyc == issue_at && !t_we));
            check_val("mem_we", 32'(mem_we), 32'(busy && cyc == issue_at && t_we));
            check_val("m_ack", 32'(m_ack), 32'(exp_ack));
            if (busy && cyc == issue_at) begin
                check_val("issue_addr", mem_addr, t_addr);
                check_val("issue_unit", 32'({mem_rd_unit, mem_wd_unit}), 32'({t_unit, t_unit}));
                if (t_we) check_val("issue_wd", mem_wd, t_wd);
            end
            if (busy && cyc > issue_at && cyc < ack_at)
                check_val("wait_addr_hold", mem_addr, t_addr);
            if (exp_ack != '0) begin
                check_val("ack_fault", 32'(m_access_fault), 32'(t_flt));
                check_val("ack_misaligned", 32'(m_addr_misaligned), 32'(t_mis));
                if (!t_we || t_flt || t_mis) check_val("ack_rd", m_rd, exp_rd);
            end
        end
        ack_prev    = m_ack;
        ack_rd_prev = m_rd;
        ack_af_prev = m_access_fault;
        ack_am_prev = m_addr_misaligned;

        if (reset) begin
            busy     = 1'b0;
            mdl_last = MASTERS - 1;
        end else if (busy && cyc == ack_at) begin
            busy     = 1'b0;
            mdl_last = owner;
        end else if (!busy && m_req != '0) begin
            found = 1'b0;
            for (int k = 1; k <= MASTERS; k++) begin
                cand = (mdl_last + k) % MASTERS;
                if (!found && m_req[cand]) begin
                    found = 1'b1;
                    owner = cand;
                end
            end
            t_we   = m_we[owner];
            t_addr = m_addr[32*owner +: 32];
            t_wd   = m_wd[32*owner +: 32];
            t_unit = m_unit[2*owner +: 2];
            t_flt  = mmu_fault(t_addr, t_we);
            t_mis  = mmu_misaligned(t_addr, t_unit);
            if (t_flt || t_mis)                  exp_rd = '0;
            else if (t_addr[31:12] == 20'h40000) exp_rd = shadow[t_addr[5:2]];
            else                                 exp_rd = rom_word(t_addr);
            if (t_we && !t_flt && !t_mis) shadow[t_addr[5:2]] = t_wd;
            busy     = 1'b1;
            issue_at = cyc + 1;
            ack_at   = cyc + 1 + ((t_we || t_flt || t_mis) ? 1 : 1 + RD_LATENCY);
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] pick_addr();
        case ($urandom % 8)
            0, 1, 2, 3, 4: return 32'h4000_0000 + 4 * ($urandom % 16);
            5:             return 32'h4000_0000 + ($urandom % 64);
            6:             return 32'h8000_0000 + 4 * ($urandom % 16);
            default:       return 32'h0000_1000;
        endcase
    endfunction

    task automatic rand_fields(input int i, input bit reads_only);
        m_we[i]            = reads_only ? 1'b0 : 1'($urandom % 2);
        m_addr[32*i +: 32] = pick_addr();
        m_wd[32*i +: 32]   = $urandom;
        m_unit[2*i +: 2]   = ($urandom % 4 == 0) ? 2'($urandom % 2) : 2'd2;
    endtask

    task automatic start_txn(input int m, input logic we, input logic [31:0] a,
                             input logic [31:0] wd, input logic [1:0] u);
        m_req[m]           = 1'b1;
        m_we[m]            = we;
        m_addr[32*m +: 32] = a;
        m_wd[32*m +: 32]   = wd;
        m_unit[2*m +: 2]   = u;
    endtask

    // Waits for master m's ack, then drops its request; returns cycles taken.
    task automatic wait_ack(input int m, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ack_prev[m] && n < 40);
        if (!ack_prev[m]) check_val("ack_timeout", 32'(n), 32'(0));
        m_req[m] = 1'b0;
    endtask

    int lat;

    initial begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_mem_addr", mem_addr, 32'h0);
        check_val("rst_m_rd", m_rd, 32'h0);
        reset = 1'b0;

        // Write then read back through the other master.
        start_txn(0, 1'b1, 32'h4000_0000, 32'hDEAD_BEEF, 2'd2);
        wait_ack(0, lat);
        check_val("wr_latency", 32'(lat), 32'd3);
        check_val("wr_fault", 32'(ack_af_prev), 32'd0);
        start_txn(1, 1'b0, 32'h4000_0000, 32'h0, 2'd2);
        wait_ack(1, lat);
        check_val("rd_latency", 32'(lat), 32'(3 + RD_LATENCY));
        check_val("rd_data", ack_rd_prev, 32'hDEAD_BEEF);

        // Write to ROM faults and skips WAIT.
        start_txn(0, 1'b1, 32'h8000_0000, 32'h1234_5678, 2'd2);
        wait_ack(0, lat);
        check_val("rom_wr_latency", 32'(lat), 32'd3);
        check_val("rom_wr_fault", 32'(ack_af_prev), 32'd1);
        check_val("rom_wr_rd", ack_rd_prev, 32'h0);

        // Misaligned word read.
        start_txn(0, 1'b0, 32'h4000_0002, 32'h0, 2'd2);
        wait_ack(0, lat);
        check_val("mis_latency", 32'(lat), 32'd3);
        check_val("mis_flag", 32'(ack_am_prev), 32'd1);
        check_val("mis_rd", ack_rd_prev, 32'h0);

        // Reset during WAIT aborts the read.
        start_txn(0, 1'b0, 32'h4000_0000, 32'h0, 2'd2);
        @(posedge clk); #1;          // ISSUE
        @(posedge clk); #1;          // WAIT
        reset = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        m_req[0] = 1'b0;
        start_txn(1, 1'b0, 32'h4000_0004, 32'h0, 2'd2);
        @(negedge clk);
        check_val("rst_wait_grant", 32'(grant), 32'd0);
        check_val("rst_wait_re_we", 32'({mem_re, mem_we}), 32'd0);
        check_val("rst_wait_ack", 32'(m_ack), 32'd0);
        wait_ack(1, lat);
        check_val("post_rst_ack_seen", 32'(ack_prev), 32'b10);

        // Both masters request reads continuously: grants must alternate.
        m_req = '1;
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < MASTERS; i++) rand_fields(i, 1'b1);
            @(posedge clk); #1;
        end
        m_req = '0;
        repeat (8) @(posedge clk);
        #1;

        // Random traffic with legal master behaviour.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < MASTERS; i++) begin
                if (ack_prev[i]) begin
                    m_req[i] = 1'($urandom % 2);
                    rand_fields(i, 1'b0);
                end else if (!m_req[i] && $urandom % 3 == 0) begin
                    m_req[i] = 1'b1;
                    rand_fields(i, 1'b0);
                end else if (m_req[i] && $urandom % 4 == 0) begin
                    rand_fields(i, 1'b0);
                end
            end
            @(posedge clk); #1;
        end
        // Let the final transaction drain; requests are dropped only on ack.
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < MASTERS; i++) if (ack_prev[i]) m_req[i] = 1'b0;
            @(posedge clk); #1;
        end
        m_req = '0;
        repeat (8) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single CPU-side memory port of the mmu among MASTERS requesters, e.g. cpu and a debug/DMA loader.
- Each requester issues one transaction at a time with a req/ack handshake.
- The arbiter picks a winner round-robin, drives the mmu port for one issue cycle, and holds the address through the device read latency.
- It returns the read data and the mmu fault flags to the owner with a one-cycle ack.

Parameters:
- MASTERS, 2, number of requesters (2..8).
- RD_LATENCY, 1, cycles from the issue cycle to valid mem_rd (0..7); 1 matches the registered rom/ram.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- m_req  in  MASTERS  per-master request; held high until the matching m_ack.
- m_we  in  MASTERS  1 = write, 0 = read.
- m_addr  in  MASTERS*32  byte address, master i at bits [32i+31:32i].
- m_wd  in  MASTERS*32  write data.
- m_unit  in  MASTERS*2  access size, same encoding as mem_rd_unit/mem_wd_unit.
- m_ack  out  MASTERS  one-hot, one-cycle completion pulse.
- m_rd  out  32  read data; valid while any m_ack is high.
- m_access_fault  out  1  mmu access_fault of the completed transaction; valid with m_ack.
- m_addr_misaligned  out  1  mmu addr_misaligned of the completed transaction; valid with m_ack.
- grant  out  MASTERS  one-hot current owner; 0 in IDLE.
- mem_re  out  1  to mmu re.
- mem_we  out  1  to mmu we.
- mem_addr  out  32  to mmu addr.
- mem_wd  out  32  to mmu wd.
- mem_rd_unit  out  2  to mmu rd_unit.
- mem_wd_unit  out  2  to mmu wd_unit.
- mem_rd  in  32  from mmu rd.
- access_fault  in  1  from mmu; combinational from the current mem_* signals.
- addr_misaligned  in  1  from mmu; combinational from the current mem_* signals.

Behaviour:
- Reset:
  - State IDLE; all outputs registered and 0.
  - RR pointer last = MASTERS-1, so master 0 wins first.
  - Reset in any state aborts the transaction: no ack, no further mem_re/mem_we.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any m_req, choose the first requester scanning from last+1 with wrap-around.
  - Latch its we/addr/wd/unit, set grant, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (exactly one cycle):
  - Drive mem_re = !we and mem_we = we.
  - Drive mem_addr and mem_wd; drive the latched unit on both mem_rd_unit and mem_wd_unit.
  - Sample access_fault and addr_misaligned.
  - If either fault: m_rd = 0, go to DONE.
  - Else if write: go to DONE.
  - Else if RD_LATENCY = 0: capture mem_rd, go to DONE.
  - Else: load cnt = RD_LATENCY-1, go to WAIT.
- WAIT:
  - mem_re = mem_we = 0.
  - mem_addr and the units are held stable, because mmu routes rd by address.
  - cnt == 0: capture mem_rd, go to DONE. Otherwise decrement cnt.
- DONE:
  - m_ack[owner] = 1 for one cycle, with m_rd and both fault flags.
  - last = owner; grant cleared at exit; go to IDLE.
- Master side:
  - Fields are captured at grant, so the master may change them after grant.
  - m_req must stay high until ack.
  - m_req still high in the cycle after ack is a new transaction.
  - Dropping m_req before ack is illegal; the transaction still completes and the ack is still issued.
- Latency (req seen in IDLE to ack): write or faulted access = 3 cycles; read = 3 + RD_LATENCY cycles.
- Exactly one transaction outstanding. mem_re and mem_we are never high together and never high outside ISSUE.
- Fairness: with all masters requesting continuously, grants rotate 0,1,..,MASTERS-1, so no master waits more than MASTERS-1 transactions.
- Simultaneous requests in IDLE are resolved in the same cycle. A request arriving during ISSUE/WAIT/DONE waits for the next IDLE.

Test Plan:
- Master0 writes 0xDEADBEEF to 0x4000_0000, word unit, req at cycle 0 → mem_we=1 only in cycle 1; m_ack[0] in cycle 2; both faults 0.
- Master1 reads 0x4000_0000 (RD_LATENCY=1) → mem_re=1 in cycle 1; mem_addr held in cycle 2; m_ack[1] in cycle 3 with m_rd = 0xDEADBEEF.
- Both masters hold req high continuously after reset → grant sequence 0,1,0,1; each ack arrives 4 cycles after the previous on reads; no starvation.
- Master0 writes to 0x8000_0000 (rom, read-only) → m_ack[0] with m_access_fault=1, m_rd=0, WAIT skipped.
- Word read at 0x4000_0002 → ack 3 cycles after req with m_addr_misaligned=1 and m_rd=0.
- Reset asserted for one cycle while in WAIT → no m_ack; next cycle grant=0 and mem_re=mem_we=0; a fresh req from master 1 alone is granted.
